// File: rtl/kamacore_datatypes.sv
// Shared kamacore pipeline types: stage payload structs and sizing helpers.
package kamacore_datatypes;

  localparam int CPU_WIDTH      = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef struct packed {
    logic [CPU_WIDTH-1:0] pc;
    logic [CPU_WIDTH-1:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [CPU_WIDTH-1:0]      pc;
    logic [CPU_WIDTH-1:0]      operand_a;
    logic [CPU_WIDTH-1:0]      operand_b;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [3:0]                alu_op;
    logic                      reg_write;
  } id_ex_t;

  typedef struct packed {
    logic [CPU_WIDTH-1:0]      alu_result;
    logic [CPU_WIDTH-1:0]      store_data;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      mem_read;
    logic                      mem_write;
    logic                      reg_write;
  } ex_mem_t;

  typedef struct packed {
    logic [CPU_WIDTH-1:0]      wb_data;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_write;
  } mem_wb_t;

  // Pointer width never collapses to zero bits, even for a single-entry buffer.
  function automatic int ptr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/kamacore_sat_counter.sv
// Saturating event counter: counts inc cycles, sticks at all-ones.
module kamacore_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_reg <= '0;
    end else if (inc && (value_reg != '1)) begin
      value_reg <= value_reg + 1'b1;
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/kamacore_pipeline_buffer.sv
// Elastic inter-stage buffer: DEPTH-entry circular FIFO with valid/ready,
// synchronous flush and a saturating upstream-stall counter.
module kamacore_pipeline_buffer
  import kamacore_datatypes::*;
#(
  parameter int DATA_WIDTH      = 96,
  parameter int DEPTH           = 2,
  parameter int STALL_CNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [STALL_CNT_WIDTH-1:0]   stall_count
);

  localparam int PW    = ptr_width(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);
  // Storage is sized to the full pointer range so any pointer value indexes cleanly.
  localparam int NSLOT = 1 << PW;

  logic [DATA_WIDTH-1:0] mem_reg [NSLOT];
  logic [PW-1:0]         wp_reg;
  logic [PW-1:0]         rp_reg;
  logic [CW-1:0]         count_reg;
  logic                  push;
  logic                  pop;
  logic                  stall_inc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count_reg != CW'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign out_data  = mem_reg[rp_reg];
  assign count     = count_reg;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign stall_inc = in_valid && !in_ready && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_reg    <= '0;
      rp_reg    <= '0;
      count_reg <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (flush) begin
      // Squash drops occupancy only; stale storage is unreachable once pointers reset.
      wp_reg    <= '0;
      rp_reg    <= '0;
      count_reg <= '0;
    end else begin
      if (push) begin
        mem_reg[wp_reg] <= in_data;
        wp_reg          <= ptr_inc(wp_reg);
      end
      if (pop) begin
        rp_reg <= ptr_inc(rp_reg);
      end
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  kamacore_sat_counter #(
    .WIDTH(STALL_CNT_WIDTH)
  ) u_stall_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall_inc),
    .value(stall_count)
  );

endmodule

// File: tb/tb_kamacore_pipeline_buffer.sv
// Bench for kamacore_pipeline_buffer: three instances (DEPTH 2/3/4), vector table,
// directed corner sequences and a queue-based random reference model.
module tb_kamacore_pipeline_buffer;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          flush_v     [3];
  logic          in_valid_v  [3];
  logic          in_ready_v  [3];
  logic [DW-1:0] in_data_v   [3];
  logic          out_valid_v [3];
  logic          out_ready_v [3];
  logic [DW-1:0] out_data_v  [3];
  logic [31:0]   count_v     [3];
  logic [31:0]   stall_v     [3];

  // Instance 0: DEPTH=2, 1: DEPTH=3 with 4-bit stall counter, 2: DEPTH=4.
  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int D  = gi + 2;
    localparam int SW = (gi == 1) ? 4 : 32;
    logic [$clog2(D+1)-1:0] cnt;
    logic [SW-1:0]          st;
    kamacore_pipeline_buffer #(
      .DATA_WIDTH(DW), .DEPTH(D), .STALL_CNT_WIDTH(SW)
    ) u_dut (
      .clk(clk), .rst(rst), .flush(flush_v[gi]),
      .in_valid(in_valid_v[gi]), .in_ready(in_ready_v[gi]), .in_data(in_data_v[gi]),
      .out_valid(out_valid_v[gi]), .out_ready(out_ready_v[gi]), .out_data(out_data_v[gi]),
      .count(cnt), .stall_count(st)
    );
    assign count_v[gi] = 32'(cnt);
    assign stall_v[gi] = 32'(st);
  end

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic f, input logic v, input logic r, input logic [DW-1:0] d);
    flush_v[k] = f; in_valid_v[k] = v; out_ready_v[k] = r; in_data_v[k] = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    idle_all();
    #1 rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  typedef struct {
    logic          f;
    logic          v;
    logic          r;
    logic [DW-1:0] d;
    logic          e_ov;
    logic [DW-1:0] e_od;
    int            e_cnt;
    logic          e_ir;
  } vec_t;

  vec_t tbl [11];
  logic [DW-1:0] mq [$];

  initial begin
    // Each row: inputs this cycle, and outputs expected this cycle (before the edge).
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 16'h00A5, 1'b0, 16'h0000, 0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h00A5, 1, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 16'h0011, 1'b0, 16'h0000, 0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 16'h0022, 1'b1, 16'h0011, 1, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 16'h0033, 1'b1, 16'h0011, 2, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0022, 1, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 16'h0044, 1'b1, 16'h0022, 1, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 16'h0055, 1'b0, 16'h0000, 0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0055, 1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 0, 1'b1};

    do_reset();
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", in_ready_v[k], 1);
      chk("rst_out_valid", out_valid_v[k], 0);
      chk("rst_out_data", out_data_v[k], 0);
      chk("rst_count", count_v[k], 0);
      chk("rst_stall", stall_v[k], 0);
    end

    // Vector table on DEPTH=2: single push latency, full, flush, post-flush reuse.
    for (int i = 0; i < 11; i++) begin
      drive(0, tbl[i].f, tbl[i].v, tbl[i].r, tbl[i].d);
      chk($sformatf("tbl%0d_out_valid", i), out_valid_v[0], tbl[i].e_ov);
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_data", i), out_data_v[0], tbl[i].e_od);
      chk($sformatf("tbl%0d_count", i), count_v[0], tbl[i].e_cnt);
      chk($sformatf("tbl%0d_in_ready", i), in_ready_v[0], tbl[i].e_ir);
      step();
    end
    chk("tbl_stall", stall_v[0], 1);

    // Full throughput on DEPTH=2.
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      drive(0, 1'b0, c < 16, 1'b1, DW'(c));
      chk("thr_in_ready", in_ready_v[0], 1);
      chk("thr_out_valid", out_valid_v[0], c != 0);
      if (c != 0) chk("thr_out_data", out_data_v[0], c - 1);
      step();
    end
    chk("thr_stall", stall_v[0], 0);
    chk("thr_count", count_v[0], 0);

    // Backpressure on DEPTH=3.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(1, 1'b0, 1'b1, 1'b0, DW'(c + 1));
      chk("bp_in_ready", in_ready_v[1], c < 3);
      step();
    end
    chk("bp_count", count_v[1], 3);
    chk("bp_stall", stall_v[1], 2);
    for (int c = 0; c < 3; c++) begin
      drive(1, 1'b0, 1'b0, 1'b1, '0);
      chk("bp_drain_data", out_data_v[1], c + 1);
      step();
    end
    chk("bp_drain_empty", out_valid_v[1], 0);

    // Flush with simultaneous push and pop on DEPTH=4.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(2, 1'b0, 1'b1, 1'b0, DW'(16'h0100 + c));
      step();
    end
    chk("fl_pre_count", count_v[2], 3);
    drive(2, 1'b1, 1'b1, 1'b1, 16'h00EE);
    step();
    drive(2, 1'b0, 1'b1, 1'b0, 16'h0077);
    chk("fl_count", count_v[2], 0);
    chk("fl_out_valid", out_valid_v[2], 0);
    chk("fl_in_ready", in_ready_v[2], 1);
    chk("fl_stall", stall_v[2], 0);
    step();
    drive(2, 1'b0, 1'b0, 1'b1, '0);
    chk("fl_next_data", out_data_v[2], 16'h0077);
    chk("fl_next_count", count_v[2], 1);
    step();
    chk("fl_final_count", count_v[2], 0);

    // Wrap-around on DEPTH=3 with two entries in flight.
    do_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1, 1'b0, 1'b1, 1'b0, DW'(100 + c));
      step();
    end
    for (int c = 0; c < 10; c++) begin
      drive(1, 1'b0, 1'b1, 1'b1, DW'(102 + c));
      chk("wrap_data", out_data_v[1], 100 + c);
      chk("wrap_count", count_v[1], 2);
      step();
    end

    // Async reset between edges with two entries held in DEPTH=2.
    do_reset();
    for (int c = 0; c < 2; c++) begin
      drive(0, 1'b0, 1'b1, 1'b0, DW'(16'h0A00 + c));
      step();
    end
    drive(0, 1'b0, 1'b0, 1'b0, '0);
    chk("ar_pre_count", count_v[0], 2);
    #2 rst = 1'b0;
    #1;
    chk("ar_out_valid", out_valid_v[0], 0);
    chk("ar_count", count_v[0], 0);
    chk("ar_in_ready", in_ready_v[0], 1);
    chk("ar_out_data", out_data_v[0], 0);
    step();
    rst = 1'b1;

    // Stall saturation at 15 on the 4-bit counter.
    do_reset();
    for (int c = 0; c < 23; c++) begin
      drive(1, 1'b0, 1'b1, 1'b0, DW'(c));
      step();
    end
    chk("sat_stall", stall_v[1], 15);

    // Random stimulus against a queue reference, one instance at a time.
    for (int k = 0; k < 3; k++) begin
      int          dep;
      logic [31:0] smax;
      logic [31:0] mstall;
      do_reset();
      mq.delete();
      dep    = k + 2;
      smax   = (k == 1) ? 32'd15 : 32'hFFFF_FFFF;
      mstall = 0;
      for (int c = 0; c < 300; c++) begin
        logic          f, v, r, ir, ov;
        logic [DW-1:0] d;
        f = ($urandom_range(9) == 0);
        v = ($urandom_range(9) < 7);
        r = 1'($urandom_range(1));
        d = DW'($urandom);
        drive(k, f, v, r, d);
        ir = (mq.size() != dep);
        ov = (mq.size() != 0);
        chk("rnd_out_valid", out_valid_v[k], ov);
        if (ov) chk("rnd_out_data", out_data_v[k], mq[0]);
        chk("rnd_count", count_v[k], mq.size());
        chk("rnd_in_ready", in_ready_v[k], ir);
        chk("rnd_stall", stall_v[k], mstall);
        if (v && !ir && !f && mstall != smax) mstall++;
        if (f) begin
          mq.delete();
        end else begin
          if (ov && r) void'(mq.pop_front());
          if (v && ir) mq.push_back(d);
        end
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/kamacore_pipeline_buffer.md
# kamacore_pipeline_buffer

Parametrised inter-stage pipeline buffer for the kamacore five-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB boundaries). It replaces the fixed single-register stage latch with a DEPTH-entry elastic buffer. The buffer carries a valid/ready handshake, a synchronous flush for branch/exception squash, and a saturating stall-cycle counter for performance monitoring. Upstream stages push stage payloads; downstream stages pop them in order.

## Interface
Parameters:
- DATA_WIDTH, 96, payload width in bits (packed stage struct).
- DEPTH, 2, number of entries; legal range 1..8; need not be a power of two.
- STALL_CNT_WIDTH, 32, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous squash of all buffered entries.
- in_valid  in  1  upstream presents a payload.
- in_ready  out  1  buffer accepts a payload this cycle.
- in_data  in  DATA_WIDTH  upstream payload.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes head this cycle.
- out_data  out  DATA_WIDTH  head payload.
- count  out  $clog2(DEPTH+1)  current occupancy.
- stall_count  out  STALL_CNT_WIDTH  saturating count of upstream-stall cycles.

## Operation
- Storage: DEPTH-entry circular array with write pointer wp, read pointer rp, and occupancy register count.
- Pointer width is max(1, $clog2(DEPTH)). A pointer equal to DEPTH-1 wraps to 0 on increment.
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = (count != DEPTH). It depends only on registered state and has no combinational path from out_ready.
- out_valid = (count != 0). out_data = mem[rp], driven from registered storage.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full: in_ready=0, so no push occurs even when a pop happens the same cycle. DEPTH=1 therefore gives half throughput; DEPTH>=2 sustains one transfer per cycle.
- Empty: out_valid=0. out_ready is ignored and no pointer moves.
- flush (priority over push and pop):
  - Next cycle: count=0, wp=rp=0, out_valid=0.
  - A push or pop in the flush cycle is discarded.
  - Storage contents are not cleared.
- stall_count increments each cycle in which in_valid && !in_ready && !flush. It saturates at all-ones, never wraps, and is cleared only by reset.
- Reset (rst=0, asynchronous):
  - count=0, wp=rp=0, stall_count=0, all storage entries=0.
  - Outputs during and after reset: in_ready=1, out_valid=0, out_data=0, count=0, stall_count=0.
- Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.

## Timing
- Latency: a payload pushed in cycle N is visible on out_data/out_valid in cycle N+1 when the buffer was empty.
- in_ready and out_valid change only after a clock edge or on asynchronous reset.
- Ordering is strictly FIFO. No bypass path from in_data to out_data.
- After flush in cycle N: in_ready=1 and out_valid=0 in cycle N+1. A new push is accepted in cycle N+1.
- Reset release: the first push is accepted on the first rising edge with rst=1.

## Structure
- Shared package kamacore_datatypes holds:
  - CPU_WIDTH and REG_ADDR_WIDTH;
  - the packed per-stage payload structs (if_id_t, id_ex_t, ex_mem_t, mem_wb_t), whose $bits set DATA_WIDTH at each instantiation;
  - a localparam function for pointer width, max(1, $clog2(n)).
- One sub-module, kamacore_sat_counter, contains the stall counter. Parameters: WIDTH. Ports: clk, rst, inc, value.
- The FIFO core stays in the top module.

## Test plan
- Reset then a single push: DEPTH=2, push 0xA5 in cycle 1. Required: out_valid=1 and out_data=0xA5 in cycle 2, count=1; pop in cycle 2 gives count=0 in cycle 3.
- Full throughput: DEPTH=2, in_valid and out_ready held high for 16 cycles with data 0..15. Required: out_data 0..15 in order, one per cycle, in_ready never low, stall_count=0.
- Full and backpressure: DEPTH=3, out_ready=0, push 5 values. Required: in_ready=0 after 3 accepted, count=3, stall_count=2; release out_ready and the outputs are the first three values in order.
- Flush with a simultaneous push/pop: DEPTH=4 holding 3 entries; assert flush, in_valid and out_ready in one cycle. Required next cycle: count=0, out_valid=0, the pushed value never appears, stall_count unchanged.
- Wrap-around, non-power-of-two: DEPTH=3, 10 interleaved push/pop rounds. Required: pointers wrap 2->0, data order preserved, count never exceeds 3.
- Async reset mid-stream plus saturation:
  - rst low between clock edges with count=2. Required: out_valid=0 and count=0 immediately.
  - Separately, STALL_CNT_WIDTH=4 with a 20-cycle stall. Required: stall_count holds at 15.
